// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and parameter checks for the serial magnitude comparator.
package cmp_pkg;

  // Controller states: waiting for operands, stepping digits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot comparison outcome as presented on the output flags.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  // A digit width is usable only if it tiles the operand exactly.
  function automatic bit steps_ok(input int n, input int d);
    return (n >= 1) && (d >= 1) && (d <= n) && ((n % d) == 0);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cmp_digit.sv
// Unsigned compare of one DIGIT-bit slice; purely combinational.
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with signed/unsigned mode and
// valid/ready handshakes. Signed operands are turned into offset binary on
// accept so every digit step is a plain unsigned compare.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIGIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb,
  output logic         busy
);

  localparam int STEPS = (DIGIT > 0) ? (N / DIGIT) : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

  if (!steps_ok(N, DIGIT)) begin : g_bad_param
    $error("serial_magnitude_comparator: DIGIT must divide N and lie in 1..N");
  end

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] count_q, count_d;
  logic         decided_q, decided_d;
  logic         gt_q, gt_d, lt_q, lt_d;
  cmp_result_t  flags_q, flags_d;

  logic dig_gt, dig_lt;
  logic new_gt, new_lt;

  // The operand registers shift left each step, so the current digit is
  // always the top DIGIT bits.
  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[N-1 -: DIGIT]),
    .y  (b_q[N-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  // First unequal digit wins; once decided, later digits cannot change it.
  assign new_gt = gt_q | (~decided_q & dig_gt);
  assign new_lt = lt_q | (~decided_q & dig_lt);

  // State, operand, accumulator and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      flags_q   <= flags_d;
    end
  end

  // Next-state and datapath control for accept, digit stepping and retire.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    flags_d   = flags_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a ^ (signed_mode ? MSB_MASK : '0);
          b_d       = b ^ (signed_mode ? MSB_MASK : '0);
          count_d   = '0;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        a_d       = a_q << DIGIT;
        b_d       = b_q << DIGIT;
        decided_d = decided_q | dig_gt | dig_lt;
        gt_d      = new_gt;
        lt_d      = new_lt;
        count_d   = count_q + CW'(1);
        if (count_q == CW'(STEPS - 1)) begin
          flags_d.eq = ~(new_gt | new_lt);
          flags_d.gt = new_gt;
          flags_d.lt = new_lt;
          count_d    = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          flags_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign aeqb      = flags_q.eq;
  assign agtb      = flags_q.gt;
  assign altb      = flags_q.lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed table plus corner sequences on an N=8/DIGIT=2 instance, and a
// random sweep on (8,8), (8,1) and (12,3) instances.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic       aeqb, agtb, altb, busy;
  logic [7:0] a, b;

  int total = 0;
  int bad   = 0;

  serial_magnitude_comparator #(.N(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .aeqb(aeqb), .agtb(agtb), .altb(altb), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at #1 after an edge, accept on the next edge, then count
  // edges until out_valid appears. Operands are scrambled after accept.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tm,
                       output int lat);
    a = ta; b = tb_v; signed_mode = tm; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    chk("busy_after_accept", 32'({busy, in_ready}), 32'b10);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retire_state", 32'({out_valid, in_ready, busy}), 32'b010);
    chk("retire_flags", 32'({aeqb, agtb, altb}), 32'b000);
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vm;
    logic [2:0] exp; // {eq, gt, lt}
  } vec_t;

  vec_t vecs[10];

  // Random sweep instances, each with its own reset and driver.
  logic sw_rst;
  initial begin
    sw_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 sw_rst = 1'b0;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int NW = (gi == 2) ? 12 : 8;
    localparam int DW = (gi == 0) ? 8 : (gi == 1) ? 1 : 3;
    localparam int ST = NW / DW;

    logic          iv, ir, md, ov, ordy, eq, gt, lt, bz;
    logic [NW-1:0] xa, xb;
    logic          done = 1'b0;

    serial_magnitude_comparator #(.N(NW), .DIGIT(DW)) u_dut (
      .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir),
      .a(xa), .b(xb), .signed_mode(md), .out_valid(ov),
      .out_ready(ordy), .aeqb(eq), .agtb(gt), .altb(lt), .busy(bz)
    );

    initial begin
      logic [NW-1:0]        x, y;
      logic signed [NW-1:0] sx, sy;
      logic                 m;
      logic [2:0]           e;
      int                   lat;
      iv = 1'b0; ordy = 1'b0; md = 1'b0; xa = '0; xb = '0;
      @(negedge sw_rst); @(posedge clk); #1;
      for (int t = 0; t < 1000; t++) begin
        x = NW'($urandom);
        y = (t % 8 == 0) ? x : NW'($urandom);
        m = 1'($urandom_range(0, 1));
        sx = x; sy = y;
        e[2] = (x == y);
        e[1] = m ? (sx > sy) : (x > y);
        e[0] = m ? (sx < sy) : (x < y);
        xa = x; xb = y; md = m; iv = 1'b1;
        chk("sweep_in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;
        iv = 1'b0; xa = NW'($urandom); xb = NW'($urandom);
        lat = 0;
        while (!ov && lat < 50) begin
          @(posedge clk); #1;
          lat++;
        end
        $display("sweep N=%0d D=%0d a=%0h b=%0h s=%0d lat=%0d flags=%b exp=%b",
                 NW, DW, x, y, m, lat, {eq, gt, lt}, e);
        chk("sweep_latency", 32'(lat), 32'(ST));
        chk("sweep_flags", 32'({eq, gt, lt}), 32'(e));
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("sweep_retire", 32'({ov, ir, eq, gt, lt}), 32'b01000);
      end
      done = 1'b1;
    end
  end

  initial begin
    int lat;
    int waited;
    vecs[0] = '{8'h80, 8'h7F, 1'b0, 3'b010};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 3'b001};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 3'b001};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 3'b010};
    vecs[4] = '{8'h5A, 8'h5A, 1'b0, 3'b100};
    vecs[5] = '{8'h5B, 8'h5A, 1'b0, 3'b010};
    vecs[6] = '{8'h5A, 8'h5B, 1'b1, 3'b001};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 3'b010};
    vecs[8] = '{8'h03, 8'h10, 1'b0, 3'b001};
    vecs[9] = '{8'h7F, 8'h7F, 1'b1, 3'b100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({in_ready, out_valid, busy, aeqb, agtb, altb}), 32'b100000);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].vm, lat);
      $display("txn a=%02h b=%02h s=%0d lat=%0d flags=%b exp=%b",
               vecs[i].va, vecs[i].vb, vecs[i].vm, lat, {aeqb, agtb, altb}, vecs[i].exp);
      chk("table_latency", 32'(lat), 32'd4);
      chk("table_flags", 32'({aeqb, agtb, altb}), 32'(vecs[i].exp));
      retire();
    end

    // Backpressure: result holds while out_ready is low; in_valid is ignored.
    issue(8'h80, 8'h7F, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 32'({out_valid, in_ready, busy, aeqb, agtb, altb}), 32'b101010);
      in_valid = k[0]; a = 8'h00; b = 8'hFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    $display("txn backpressure hold flags=%b", {aeqb, agtb, altb});
    retire();
    @(posedge clk); #1;
    chk("bp_no_queue", 32'(busy), 32'd0);

    // Reset on the second BUSY edge discards the operation.
    a = 8'h80; b = 8'h7F; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", 32'({in_ready, out_valid, busy, aeqb, agtb, altb}), 32'b100000);
    $display("txn reset mid-busy state=%b", {in_ready, out_valid, busy});
    issue(8'h03, 8'h10, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_flags", 32'({aeqb, agtb, altb}), 32'b001);
    $display("txn a=03 b=10 after reset lat=%0d flags=%b", lat, {aeqb, agtb, altb});
    retire();

    // Reset while holding a result in DONE.
    issue(8'h5A, 8'h5A, 1'b0, lat);
    chk("done_flags", 32'({aeqb, agtb, altb}), 32'b100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_done", 32'({in_ready, out_valid, busy, aeqb, agtb, altb}), 32'b100000);
    $display("txn reset in done state=%b", {in_ready, out_valid, busy});

    // Wait for the parameter sweep, bounded.
    waited = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    chk("sweep_completed",
        32'({g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}), 32'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
